// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: PC/instruction widths, halt opcode, fetch FSM states.
// No logic and no latency of its own; it only holds types and a decode helper.
// Imported by the prefetch interface, the queue and the prefetch top.
package cpu_pkg;

  localparam int PC_W    = 8;
  localparam int INSTR_W = 16;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // True when the opcode field of an instruction is the halt opcode.
  function automatic logic is_halt(input logic [INSTR_W-1:0] instr);
    return instr[INSTR_W-1 -: 4] == OP_HALT;
  endfunction

endpackage

// File: rtl/instr_prefetch_if.sv
// Bundle of the prefetcher's imem, redirect and decode-side signals.
// No latency; wiring only. Decode backpressure travels on dec_ready.
// master = prefetch unit, slave = surrounding core / imem / decode.
interface instr_prefetch_if;
  import cpu_pkg::*;

  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_instr;
  logic               redirect;
  logic [PC_W-1:0]    redirect_pc;
  logic               dec_valid;
  logic               dec_ready;
  logic [INSTR_W-1:0] dec_instr;
  logic [PC_W-1:0]    dec_pc;
  logic               halted;

  modport master (
    output imem_addr, dec_valid, dec_instr, dec_pc, halted,
    input  imem_instr, redirect, redirect_pc, dec_ready
  );

  modport slave (
    input  imem_addr, dec_valid, dec_instr, dec_pc, halted,
    output imem_instr, redirect, redirect_pc, dec_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// DEPTH-entry queue of {pc, instr} with flush, count and a combinational head.
// Latency 1: a push is visible at the head the cycle after it is written.
// Caller must not push when full unless popping; flush beats push and pop.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_push,
  input  fetch_entry_t       i_push_dat,
  input  logic               i_pop,
  input  logic               i_flush,
  output logic [CNT_W-1:0]   o_count,
  output fetch_entry_t       o_head_dat
);

  localparam int PTR_W = $clog2(DEPTH);

  fetch_entry_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  // Pointers and occupancy; flush empties the queue without touching storage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (i_push && !i_pop)      r_count <= r_count + CNT_W'(1);
      else if (i_pop && !i_push) r_count <= r_count - CNT_W'(1);
    end
  end

  // Entry storage; data needs no reset because occupancy gates its use.
  always_ff @(posedge clk) begin
    if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_push_dat;
  end

  assign o_count    = r_count;
  assign o_head_dat = r_mem[r_rd_ptr];

endmodule

// File: rtl/instr_prefetch.sv
// Instruction prefetcher: fetch PC + RUN/HALT FSM feeding a fetch_fifo to decode.
// Latency 1: an instruction fetched in cycle N is at dec_* in cycle N+1 when empty.
// Stalls fetch when the queue is full and not popping; redirect flushes and restarts.
// Optional FETCH_STATS_EN adds flush_count (saturating total of flushed entries).
module instr_prefetch
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
`ifdef FETCH_STATS_EN
  output logic [15:0]         flush_count,
`endif
  instr_prefetch_if.master    bus
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  fetch_state_e     r_state;
  logic [PC_W-1:0]  r_fetch_pc;
  logic             r_halted;

  logic [CNT_W-1:0] w_count;
  fetch_entry_t     w_head;
  fetch_entry_t     w_push_dat;
  logic             w_pop;
  logic             w_push;

  // Redirect wins over everything: nothing is handed to decode in a flush cycle.
  assign w_pop  = bus.dec_valid && bus.dec_ready && !bus.redirect;
  assign w_push = (r_state == RUN) && !bus.redirect &&
                  ((w_count < CNT_W'(DEPTH)) || w_pop);

  assign w_push_dat = '{pc: r_fetch_pc, instr: bus.imem_instr};

  fetch_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .i_push     (w_push),
    .i_push_dat (w_push_dat),
    .i_pop      (w_pop),
    .i_flush    (bus.redirect),
    .o_count    (w_count),
    .o_head_dat (w_head)
  );

  // Fetch FSM: advance PC on each push, stop after queuing a halt, restart on redirect.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= RUN;
      r_fetch_pc <= '0;
      r_halted   <= 1'b0;
    end else if (bus.redirect) begin
      r_state    <= RUN;
      r_fetch_pc <= bus.redirect_pc;
      r_halted   <= 1'b0;
    end else if (w_push) begin
      r_fetch_pc <= r_fetch_pc + PC_W'(1);
      if (is_halt(bus.imem_instr)) begin
        r_state  <= HALT;
        r_halted <= 1'b1;
      end
    end
  end

`ifdef FETCH_STATS_EN
  logic [15:0] r_flush_count;
  logic [16:0] w_flush_sum;

  assign w_flush_sum = {1'b0, r_flush_count} + 17'(w_count);

  // Accumulate entries thrown away by redirects, pinned at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_flush_count <= '0;
    end else if (bus.redirect) begin
      r_flush_count <= w_flush_sum[16] ? 16'hFFFF : w_flush_sum[15:0];
    end
  end

  assign flush_count = r_flush_count;
`endif

  assign bus.imem_addr = r_fetch_pc;
  assign bus.dec_valid = (w_count != '0);
  assign bus.dec_instr = w_head.instr;
  assign bus.dec_pc    = w_head.pc;
  assign bus.halted    = r_halted;

endmodule

// File: tb/tb_instr_prefetch.sv
// Directed bench for instr_prefetch: vector table plus halt and async-reset sequences.
// imem model returns 16'h1000+addr, or 16'hF000 at addr 8'h03 while halt_mode is set.
// Builds with or without FETCH_STATS_EN; flush_count is checked only when present.
module tb_instr_prefetch;

  localparam int DEPTH = 4;

  logic clk;
  logic reset;
  logic halt_mode;
`ifdef FETCH_STATS_EN
  logic [15:0] flush_count;
`endif

  int n_vec;
  int n_err;

  instr_prefetch_if bus ();

  instr_prefetch #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
`ifdef FETCH_STATS_EN
    .flush_count (flush_count),
`endif
    .bus         (bus)
  );

  // Combinational instruction memory.
  assign bus.imem_instr = (halt_mode && bus.imem_addr == 8'h03) ? 16'hF000
                        : (16'h1000 + {8'h00, bus.imem_addr});

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        redir;
    logic [7:0]  rpc;
    logic        rdy;
    logic        ev;
    logic [7:0]  epc;
    logic [15:0] einstr;
    logic [7:0]  eaddr;
    logic        eh;
    logic [15:0] efc;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rst, input logic redir, input logic [7:0] rpc,
                     input logic rdy, input logic ev, input logic [7:0] epc,
                     input logic [15:0] einstr, input logic [7:0] eaddr,
                     input logic eh, input logic [15:0] efc);
    vec_t v;
    v.rst = rst; v.redir = redir; v.rpc = rpc; v.rdy = rdy;
    v.ev = ev; v.epc = epc; v.einstr = einstr; v.eaddr = eaddr;
    v.eh = eh; v.efc = efc;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Drive one cycle's inputs at the falling edge and let them settle.
  task automatic step(input logic r, input logic rd, input logic [7:0] rp, input logic dr);
    @(negedge clk);
    reset           = r;
    bus.redirect    = rd;
    bus.redirect_pc = rp;
    bus.dec_ready   = dr;
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    halt_mode = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_pc = 8'h00;
    bus.dec_ready = 1'b0;

    //   rst red rpc    rdy  ev epc    instr     addr   h  fc
    // Reset, then streaming with decode always ready.
    add(1, 0, 8'h00, 1,   0, 8'h00, 16'h0000, 8'h00, 0, 16'd0);
    add(0, 0, 8'h00, 1,   0, 8'h00, 16'h0000, 8'h00, 0, 16'd0);
    add(0, 0, 8'h00, 1,   1, 8'h00, 16'h1000, 8'h01, 0, 16'd0);
    add(0, 0, 8'h00, 1,   1, 8'h01, 16'h1001, 8'h02, 0, 16'd0);
    add(0, 0, 8'h00, 1,   1, 8'h02, 16'h1002, 8'h03, 0, 16'd0);
    // Reset, then ten cycles of decode stall: queue fills, fetch stops at 8'h04.
    add(1, 0, 8'h00, 0,   0, 8'h00, 16'h0000, 8'h00, 0, 16'd0);
    add(0, 0, 8'h00, 0,   0, 8'h00, 16'h0000, 8'h00, 0, 16'd0);
    add(0, 0, 8'h00, 0,   1, 8'h00, 16'h1000, 8'h01, 0, 16'd0);
    add(0, 0, 8'h00, 0,   1, 8'h00, 16'h1000, 8'h02, 0, 16'd0);
    add(0, 0, 8'h00, 0,   1, 8'h00, 16'h1000, 8'h03, 0, 16'd0);
    for (int k = 0; k < 6; k++)
      add(0, 0, 8'h00, 0, 1, 8'h00, 16'h1000, 8'h04, 0, 16'd0);
    // Redirect a full queue to 8'h40.
    add(0, 1, 8'h40, 0,   1, 8'h00, 16'h1000, 8'h04, 0, 16'd0);
    add(0, 0, 8'h00, 0,   0, 8'h00, 16'h0000, 8'h40, 0, 16'd4);
    add(0, 0, 8'h00, 1,   1, 8'h40, 16'h1040, 8'h41, 0, 16'd4);
    add(0, 0, 8'h00, 1,   1, 8'h41, 16'h1041, 8'h42, 0, 16'd4);
    // Redirect with one entry queued to 8'hFE: PC wraps through 8'h00.
    add(0, 1, 8'hFE, 1,   1, 8'h42, 16'h1042, 8'h43, 0, 16'd4);
    add(0, 0, 8'h00, 1,   0, 8'h00, 16'h0000, 8'hFE, 0, 16'd5);
    add(0, 0, 8'h00, 1,   1, 8'hFE, 16'h10FE, 8'hFF, 0, 16'd5);
    add(0, 0, 8'h00, 1,   1, 8'hFF, 16'h10FF, 8'h00, 0, 16'd5);
    add(0, 0, 8'h00, 1,   1, 8'h00, 16'h1000, 8'h01, 0, 16'd5);
    add(0, 0, 8'h00, 1,   1, 8'h01, 16'h1001, 8'h02, 0, 16'd5);

    foreach (tbl[i]) begin
      logic [63:0] got;
      logic [63:0] exp;
      step(tbl[i].rst, tbl[i].redir, tbl[i].rpc, tbl[i].rdy);
      got = {30'd0, bus.dec_valid,
             tbl[i].ev ? bus.dec_pc : 8'h00,
             tbl[i].ev ? bus.dec_instr : 16'h0000,
             bus.imem_addr, bus.halted};
      exp = {30'd0, tbl[i].ev, tbl[i].epc, tbl[i].einstr, tbl[i].eaddr, tbl[i].eh};
      chk($sformatf("vec%0d {valid,pc,instr,addr,halted}", i), got, exp);
`ifdef FETCH_STATS_EN
      chk($sformatf("vec%0d flush_count", i), 64'(flush_count), 64'(tbl[i].efc));
`endif
    end

    // Halt opcode at 8'h03: fetch stops after queuing it, queue still drains.
    halt_mode = 1'b1;
    step(1, 0, 8'h00, 0);
`ifdef FETCH_STATS_EN
    chk("halt_seq flush_count after reset", 64'(flush_count), 64'd0);
`endif
    step(0, 0, 8'h00, 0);
    chk("halt_seq empty after release", 64'(bus.dec_valid), 64'd0);
    step(0, 0, 8'h00, 0);
    step(0, 0, 8'h00, 0);
    step(0, 0, 8'h00, 0);
    chk("halt_seq not halted before push", 64'(bus.halted), 64'd0);
    chk("halt_seq addr 03", 64'(bus.imem_addr), 64'h03);
    step(0, 0, 8'h00, 1);
    chk("halt_seq halted after push", 64'(bus.halted), 64'd1);
    chk("halt_seq head pc0", 64'({bus.dec_valid, bus.dec_pc}), 64'h100);
    for (int k = 1; k < 4; k++) begin
      step(0, 0, 8'h00, 1);
      chk($sformatf("halt_seq drain pc%0d", k), 64'({bus.dec_valid, bus.dec_pc}),
          64'(9'h100 | 9'(k)));
    end
    chk("halt_seq halt instr", 64'(bus.dec_instr), 64'hF000);
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 8'h00, 1);
      chk($sformatf("halt_seq idle%0d {valid,addr,halted}", k),
          64'({bus.dec_valid, bus.imem_addr, bus.halted}), 64'({1'b0, 8'h04, 1'b1}));
    end
    step(0, 1, 8'h10, 1);
    chk("halt_seq halted during redirect", 64'(bus.halted), 64'd1);
    step(0, 0, 8'h00, 1);
    chk("halt_seq resumed {valid,addr,halted}",
        64'({bus.dec_valid, bus.imem_addr, bus.halted}), 64'({1'b0, 8'h10, 1'b0}));
    step(0, 0, 8'h00, 1);
    chk("halt_seq first after redirect {valid,pc,instr}",
        64'({bus.dec_valid, bus.dec_pc, bus.dec_instr}), 64'({1'b1, 8'h10, 16'h1010}));
    halt_mode = 1'b0;

    // Asynchronous reset with three entries queued.
    step(1, 0, 8'h00, 0);
    step(0, 0, 8'h00, 0);
    step(0, 0, 8'h00, 0);
    step(0, 0, 8'h00, 0);
    @(negedge clk);
    chk("areset queued before {valid,addr}",
        64'({bus.dec_valid, bus.imem_addr}), 64'({1'b1, 8'h03}));
    #2 reset = 1'b1;
    #1;
    chk("areset immediate {valid,addr,halted}",
        64'({bus.dec_valid, bus.imem_addr, bus.halted}), 64'({1'b0, 8'h00, 1'b0}));
    step(0, 0, 8'h00, 1);
    chk("areset after release valid", 64'(bus.dec_valid), 64'd0);
    step(0, 0, 8'h00, 1);
    chk("areset first {valid,pc,instr}",
        64'({bus.dec_valid, bus.dec_pc, bus.dec_instr}), 64'({1'b1, 8'h00, 16'h1000}));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/instr_prefetch.md
INSTR_PREFETCH -- requirements
Module: instr_prefetch

Interface
REQ-001 SHALL have parameter DEPTH, default 4, queue entries; legal values 2, 4, 8.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port imem_addr  output  8  fetch address to imem, equal to fetch_pc.
REQ-005 SHALL have port imem_instr  input  16  imem read data, combinational from imem_addr in the same cycle.
REQ-006 SHALL have port redirect  input  1  taken-branch flush request (the execute-stage PCSrcE).
REQ-007 SHALL have port redirect_pc  input  8  branch target, sampled when redirect=1.
REQ-008 SHALL have port dec_valid  output  1  head entry is valid.
REQ-009 SHALL have port dec_ready  input  1  decode accepts the head entry.
REQ-010 SHALL have port dec_instr  output  16  head instruction.
REQ-011 SHALL have port dec_pc  output  8  address of head instruction.
REQ-012 SHALL have port halted  output  1  high in state HALT.

Function
REQ-013 SHALL hold a FIFO of {pc[7:0], instr[15:0]} entries, DEPTH deep, with a count of 0..DEPTH.
REQ-014 SHALL pop the head when dec_valid=1 and dec_ready=1, with dec_valid = (count != 0).
REQ-015 SHALL push {fetch_pc, imem_instr} and increment fetch_pc when state=RUN, redirect=0, and either count<DEPTH or a pop occurs in the same cycle.
REQ-016 SHALL increment fetch_pc modulo 256, so 8'hFF wraps to 8'h00 with no flag.
REQ-017 SHALL support simultaneous push and pop, leaving count unchanged, including when full.
REQ-018 SHALL apply redirect with priority over push and pop: count<=0, fetch_pc<=redirect_pc, state<=RUN, and no entry leaves the FIFO that cycle.
REQ-019 SHALL use a 2-state FSM: RUN fetches; RUN->HALT when a pushed instr[15:12]==4'hF (the halt opcode), that entry itself being queued.
REQ-020 SHALL do no pushes in HALT; HALT->RUN only on redirect, and the FIFO SHALL still drain to decode in HALT.
REQ-021 SHALL keep dec_instr/dec_pc stable while dec_valid=1 and dec_ready=0.
REQ-022 SHALL have a latency of 1 cycle: an instruction fetched in cycle N is presented on dec_* in cycle N+1 when the FIFO was empty.

Reset
REQ-023 SHALL, on reset assertion, immediately set fetch_pc=0, count=0, state=RUN, dec_valid=0, halted=0, and imem_addr=0.
REQ-024 SHALL, when reset asserts mid-operation, discard queued entries; the first push after release is address 0.

Configuration
REQ-025 SHALL, with FETCH_STATS_EN defined, add output flush_count[15:0], incremented by the count discarded on each redirect, saturating at 16'hFFFF, and reset to 0.
REQ-026 SHALL, without FETCH_STATS_EN, omit the flush_count port and counter, with all other behaviour identical.

Structure
REQ-027 SHALL take PC_W=8, INSTR_W=16, OP_HALT=4'hF, and the fetch state enum {RUN, HALT} from shared package cpu_pkg.
REQ-028 SHALL implement the storage as sub-module fetch_fifo (push, pop, flush, count, head outputs), with the FSM and fetch_pc in instr_prefetch.

Verification
REQ-029 SHALL verify: reset release, dec_ready=1, imem returns 16'h1000+addr -> dec_pc 0,1,2... on consecutive cycles with dec_instr 16'h1000,16'h1001,...
REQ-030 SHALL verify: dec_ready=0 for 10 cycles -> count saturates at DEPTH=4, imem_addr holds 8'h04, and head stays pc 0 / 16'h1000.
REQ-031 SHALL verify: full FIFO plus redirect=1, redirect_pc=8'h40 -> next cycle dec_valid=0, then dec_pc=8'h40, and flush_count=4 if FETCH_STATS_EN.
REQ-032 SHALL verify: imem_instr=16'hF000 at addr 8'h03 -> halted=1 after push, entries 0..3 drain, and no pc 8'h04 appears until redirect.
REQ-033 SHALL verify: redirect_pc=8'hFE -> dec_pc sequence FE, FF, 00, 01 (wrap).
REQ-034 SHALL verify: reset asserted asynchronously with 3 entries queued -> dec_valid=0 before the next clk edge, and first dec_pc=0 after release.
